// File: rtl/id_ex_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_pkg
//
// Shared definitions for the ID/EX pipeline register:
//   - bit positions of every field inside the 12-bit control word
//   - the control-word type (flat vector plus a packed field view)
//   - the all-zero NOP control constant used for bubbles and invalid slots
//   - the two-state bubble FSM encoding
//   - gateCtrl(): forces a control word to NOP when its slot is not valid
//
// Control word layout, MSB first:
//   {lui, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
//    BranchNE, BranchEQ, ALUOp[2:0]}
// ---------------------------------------------------------------------------
package id_ex_pipe_reg_pkg;

    localparam int CTRL_W  = 12;
    localparam int ALUOP_W = 3;

    // Bit indices inside the control word
    localparam int CTRL_LUI       = 11;
    localparam int CTRL_REGDST    = 10;
    localparam int CTRL_ALUSRC    = 9;
    localparam int CTRL_MEMTOREG  = 8;
    localparam int CTRL_REGWRITE  = 7;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_BRANCHNE  = 4;
    localparam int CTRL_BRANCHEQ  = 3;
    localparam int CTRL_ALUOP_MSB = ALUOP_W - 1;
    localparam int CTRL_ALUOP_LSB = 0;

    typedef logic [CTRL_W-1:0] ctrl_word_t;

    // Field-by-field view of the same 12 bits, handy when decoding in EX
    typedef struct packed {
        logic               lui;
        logic               regDst;
        logic               aluSrc;
        logic               memToReg;
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
        logic               branchNe;
        logic               branchEq;
        logic [ALUOP_W-1:0] aluOp;
    } ctrl_fields_t;

    // A NOP must have every side-effecting bit low, so all-zero is the NOP
    localparam ctrl_word_t CTRL_NOP = '0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } pipe_state_e;

    // An invalid decode slot must never carry live control bits into EX
    function automatic ctrl_word_t gateCtrl(input logic valid, input ctrl_word_t ctrl);
        return valid ? ctrl : CTRL_NOP;
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_field.sv
// ---------------------------------------------------------------------------
// pipe_field_reg
//
// Generic pipeline field register: a W-bit flop group with synchronous
// reset, synchronous clear and load enable.  Priority per edge is
// reset > clear > enable > hold.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, clears the field
//   en_i   in   load d_i on this edge
//   clr_i  in   clear the field on this edge (beats en_i)
//   d_i    in   W-bit next value
//   q_o    out  W-bit registered value
// ---------------------------------------------------------------------------
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] field_q;
    logic [W-1:0] field_d;

    // Next value: clear wins over load, otherwise keep what we have
    always_comb begin
        field_d = field_q;
        if (clr_i) begin
            field_d = '0;
        end else if (en_i) begin
            field_d = d_i;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

    assign q_o = field_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// downstream stall and branch flush handling.
//
// Optional feature macro: ID_EX_BUBBLE_CNT_EN
//   defined   -> 16-bit wrapping counter of inserted bubbles on bubble_cnt
//   undefined -> no counter flops, bubble_cnt is constant zero
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_valid, id_ctrl               decode slot valid flag and control word
//   id_rd1, id_rd2, id_imm, id_pc4  DATA_W-bit operands, immediate, PC+4
//   id_rs, id_rt, id_rd             REG_AW-bit register numbers
//   stall_i                         downstream stall, freeze EX contents
//   flush_i                         branch-taken flush, kill entering insn
//   ex_*                            registered EX-stage copies of id_*
//   stall_o                         combinational freeze for PC and IF/ID
//   bubble_cnt                      number of bubbles inserted (optional)
//
// Per-edge priority: reset > stall_i (hold) > flush_i (bubble)
//                    > load-use hazard (bubble) > load.
// A bubble clears only valid and control; data and register-number fields
// keep their previous contents since nothing downstream looks at them.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              stall_o,
    output logic [15:0]       bubble_cnt
);

    pipe_state_e state_q;

    logic hazardRaw;
    logic hazard;
    logic bubbleEdge;
    logic loadEdge;
    logic ctrlEn;

    ctrl_word_t idCtrlGated;

    // Load-use hazard: a load in EX whose destination feeds the instruction
    // in decode.  rt is only a true source when ALUSrc is low; register 0 is
    // hard-wired so it can never create a dependency.
    assign hazardRaw = ex_valid
                     & ex_ctrl[CTRL_MEMREAD]
                     & id_valid
                     & (ex_rt != '0)
                     & ((ex_rt == id_rs) | ((ex_rt == id_rt) & ~id_ctrl[CTRL_ALUSRC]));

    // In BUBBLE the EX slot is already empty, so the qualifier is redundant
    // in normal flow; it guarantees one bubble per stalled instruction even
    // if the slot contents ever looked live again.
    assign hazard = hazardRaw & (state_q == ST_RUN);

    // IF/ID must freeze whenever EX is held or a bubble is being injected
    // underneath the dependent instruction.
    assign stall_o = stall_i | hazard;

    // Edge classification; stall_i overrides everything except reset
    assign bubbleEdge = ~stall_i & (flush_i | hazard);
    assign loadEdge   = ~stall_i & ~flush_i & ~hazard;
    assign ctrlEn     = ~stall_i;

    assign idCtrlGated = gateCtrl(id_valid, id_ctrl);

    // Valid flag and control word travel together so a bubble or an invalid
    // slot can never leave a stray RegWrite/MemWrite behind.
    pipe_field_reg #(
        .W (1 + CTRL_W)
    ) uCtrlGroup (
        .clk   (clk),
        .reset (reset),
        .en_i  (ctrlEn),
        .clr_i (bubbleEdge),
        .d_i   ({id_valid, idCtrlGated}),
        .q_o   ({ex_valid, ex_ctrl})
    );

    // Operand, immediate and PC+4 fields only move on a real load
    pipe_field_reg #(
        .W (4 * DATA_W)
    ) uDataGroup (
        .clk   (clk),
        .reset (reset),
        .en_i  (loadEdge),
        .clr_i (1'b0),
        .d_i   ({id_rd1, id_rd2, id_imm, id_pc4}),
        .q_o   ({ex_rd1, ex_rd2, ex_imm, ex_pc4})
    );

    // Register-number fields follow the same load-only rule
    pipe_field_reg #(
        .W (3 * REG_AW)
    ) uRegGroup (
        .clk   (clk),
        .reset (reset),
        .en_i  (loadEdge),
        .clr_i (1'b0),
        .d_i   ({id_rs, id_rt, id_rd}),
        .q_o   ({ex_rs, ex_rt, ex_rd})
    );

    // Bubble FSM: enter BUBBLE when a hazard bubble is taken, leave on the
    // next edge that is not stalled.  Stalls freeze the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else if (!stall_i) begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        state_q <= ST_BUBBLE;
                    end
                end
                ST_BUBBLE: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubbleCnt_q;
    logic [15:0] bubbleCnt_d;

    // Count every bubble edge, flush or hazard; natural 16-bit wrap
    always_comb begin
        bubbleCnt_d = bubbleCnt_q;
        if (bubbleEdge) begin
            bubbleCnt_d = bubbleCnt_q + 16'd1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            bubbleCnt_q <= '0;
        end else begin
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign bubble_cnt = bubbleCnt_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//
// Scoreboard bench for id_ex_pipe_reg.  Each directed vector carries a
// hand-derived stall_o value and the hand-derived edge action (reset, hold,
// bubble, load); the stimulus task turns that action into the expected EX
// contents and pushes them into a queue.  A separate monitor checks stall_o
// before the edge and every EX output after it.
// Honours ID_EX_BUBBLE_CNT_EN for the bubble_cnt expectation.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;
    import id_ex_pipe_reg_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // Hand-encoded control words
    localparam logic [11:0] C_ADDI = 12'b001010000100;
    localparam logic [11:0] C_LW   = 12'b001111000000;
    localparam logic [11:0] C_RADD = 12'b010010000010;
    localparam logic [11:0] C_SW   = 12'b001000100000;

    typedef enum {ACT_RESET, ACT_HOLD, ACT_BUBBLE, ACT_LOAD} action_e;

    typedef struct {
        logic        stallExp;
        logic        valid;
        logic [11:0] ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] cnt;
    } expect_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [11:0]       id_ctrl;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              stall_i, flush_i;
    logic              ex_valid;
    logic [11:0]       ex_ctrl;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic              stall_o;
    logic [15:0]       bubble_cnt;

    expect_t scoreQ[$];
    expect_t model;
    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_ctrl    (id_ctrl),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .id_imm     (id_imm),
        .id_pc4     (id_pc4),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .ex_valid   (ex_valid),
        .ex_ctrl    (ex_ctrl),
        .ex_rd1     (ex_rd1),
        .ex_rd2     (ex_rd2),
        .ex_imm     (ex_imm),
        .ex_pc4     (ex_pc4),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .stall_o    (stall_o),
        .bubble_cnt (bubble_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        assertCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and queue the
    // expected result of the following rising edge.
    task automatic applyStimulus(
        input logic rst, input logic stl, input logic fls, input logic vld,
        input logic [11:0] ctl,
        input logic [31:0] r1, input logic [31:0] r2,
        input logic [31:0] im, input logic [31:0] pc,
        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
        input logic expStall, input action_e act);
        @(negedge clk);
        reset    = rst;
        stall_i  = stl;
        flush_i  = fls;
        id_valid = vld;
        id_ctrl  = ctl;
        id_rd1   = r1;
        id_rd2   = r2;
        id_imm   = im;
        id_pc4   = pc;
        id_rs    = s;
        id_rt    = t;
        id_rd    = d;
        case (act)
            ACT_RESET: begin
                model.valid = 1'b0; model.ctrl = '0;
                model.rd1 = '0; model.rd2 = '0; model.imm = '0; model.pc4 = '0;
                model.rs = '0; model.rt = '0; model.rd = '0; model.cnt = '0;
            end
            ACT_BUBBLE: begin
                model.valid = 1'b0;
                model.ctrl  = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
                model.cnt   = model.cnt + 16'd1;
`endif
            end
            ACT_LOAD: begin
                model.valid = vld;
                model.ctrl  = vld ? ctl : 12'h000;
                model.rd1 = r1; model.rd2 = r2; model.imm = im; model.pc4 = pc;
                model.rs = s; model.rt = t; model.rd = d;
            end
            default: begin
            end
        endcase
        model.stallExp = expStall;
        scoreQ.push_back(model);
    endtask

    // Monitor: stall_o is combinational, so it is checked mid-cycle with the
    // new inputs applied; the EX outputs are checked just after the edge.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            #2;
            if (scoreQ.size() > 0) begin
                e = scoreQ[0];
                checkOutput("stall_o", {31'd0, stall_o}, {31'd0, e.stallExp});
                @(posedge clk);
                #1;
                e = scoreQ.pop_front();
                checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
                checkOutput("ex_ctrl", {20'd0, ex_ctrl}, {20'd0, e.ctrl});
                checkOutput("ex_rd1", ex_rd1, e.rd1);
                checkOutput("ex_rd2", ex_rd2, e.rd2);
                checkOutput("ex_imm", ex_imm, e.imm);
                checkOutput("ex_pc4", ex_pc4, e.pc4);
                checkOutput("ex_rs", {27'd0, ex_rs}, {27'd0, e.rs});
                checkOutput("ex_rt", {27'd0, ex_rt}, {27'd0, e.rt});
                checkOutput("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                checkOutput("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        int waitCycles;
        reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; id_valid = 1'b0; id_ctrl = '0;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_pc4 = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        model = '{default: '0};

        $display("[TB] starting id_ex_pipe_reg directed test");
        //            rst stl fls vld ctrl    rd1       rd2       imm       pc4       rs  rt  rd  stall act
        // Reset with every input active
        applyStimulus(1,  1,  1,  1,  C_ADDI, 32'h77,   32'h88,   32'h99,   32'h400,  8,  8,  8,  1, ACT_RESET);
        applyStimulus(1,  1,  1,  1,  C_LW,   32'h77,   32'h88,   32'h99,   32'h400,  8,  8,  8,  1, ACT_RESET);
        // Idle slot: data loads, control forced to NOP
        applyStimulus(0,  0,  0,  0,  12'h000,32'h1234, 32'h5678, 32'h9abc, 32'h100,  1,  2,  3,  0, ACT_LOAD);
        // ADDI, then a load, then a dependent R-type that must bubble once
        applyStimulus(0,  0,  0,  1,  C_ADDI, 32'd5,    32'd0,    32'd3,    32'h104,  1,  2,  2,  0, ACT_LOAD);
        applyStimulus(0,  0,  0,  1,  C_LW,   32'h100,  32'h0,    32'd4,    32'h108,  3,  8,  0,  0, ACT_LOAD);
        applyStimulus(0,  0,  0,  1,  C_RADD, 32'hAAAA, 32'hBBBB, 32'h0,    32'h10C,  8,  9,  10, 1, ACT_BUBBLE);
        applyStimulus(0,  0,  0,  1,  C_RADD, 32'hAAAA, 32'hBBBB, 32'h0,    32'h10C,  8,  9,  10, 0, ACT_LOAD);
        // Load to r0 followed by a reader of r0: no hazard
        applyStimulus(0,  0,  0,  1,  C_LW,   32'h200,  32'h0,    32'd8,    32'h110,  4,  0,  0,  0, ACT_LOAD);
        applyStimulus(0,  0,  0,  1,  C_RADD, 32'h1,    32'h2,    32'h0,    32'h114,  0,  0,  11, 0, ACT_LOAD);
        // rt matches but ALUSrc=1 means rt is not an ALU source: no hazard
        applyStimulus(0,  0,  0,  1,  C_LW,   32'h300,  32'h0,    32'd12,   32'h118,  2,  7,  0,  0, ACT_LOAD);
        applyStimulus(0,  0,  0,  1,  C_SW,   32'h310,  32'h320,  32'd16,   32'h11C,  5,  7,  0,  0, ACT_LOAD);
        // Hazard on rt together with a flush: exactly one bubble
        applyStimulus(0,  0,  0,  1,  C_LW,   32'h400,  32'h0,    32'd20,   32'h120,  1,  6,  0,  0, ACT_LOAD);
        applyStimulus(0,  0,  1,  1,  C_RADD, 32'h4444, 32'h4545, 32'h0,    32'h124,  2,  6,  12, 1, ACT_BUBBLE);
        // Invalid slot carrying a nonzero control word
        applyStimulus(0,  0,  0,  0,  C_RADD, 32'h5555, 32'h6666, 32'h7777, 32'h128,  13, 14, 15, 0, ACT_LOAD);
        applyStimulus(0,  0,  0,  1,  C_ADDI, 32'h11,   32'h0,    32'h22,   32'h200,  3,  4,  4,  0, ACT_LOAD);
        // stall_i and flush_i together for three cycles: hold everything
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 1, C_LW, 32'hDEAD, 32'hBEEF, 32'hF00D, 32'h300, 9, 9, 9, 1, ACT_HOLD);
        end
        // Hazard under stall_i holds; released stall takes the bubble
        applyStimulus(0,  0,  0,  1,  C_LW,   32'h500,  32'h0,    32'd24,   32'h204,  1,  9,  0,  0, ACT_LOAD);
        applyStimulus(0,  1,  0,  1,  C_RADD, 32'h6000, 32'h6001, 32'h0,    32'h208,  9,  3,  16, 1, ACT_HOLD);
        applyStimulus(0,  0,  0,  1,  C_RADD, 32'h6000, 32'h6001, 32'h0,    32'h208,  9,  3,  16, 1, ACT_BUBBLE);
        applyStimulus(0,  0,  0,  1,  C_RADD, 32'h6000, 32'h6001, 32'h0,    32'h208,  9,  3,  16, 0, ACT_LOAD);
        // Plain flush: bubble, data fields keep the R-type's values
        applyStimulus(0,  0,  1,  1,  C_ADDI, 32'h7000, 32'h0,    32'h7001, 32'h20C,  17, 18, 18, 0, ACT_BUBBLE);
        // Reset in the middle of a live hazard
        applyStimulus(0,  0,  0,  1,  C_LW,   32'h800,  32'h0,    32'd28,   32'h210,  1,  5,  0,  0, ACT_LOAD);
        applyStimulus(1,  0,  0,  1,  C_RADD, 32'h8000, 32'h8001, 32'h0,    32'h214,  5,  2,  19, 1, ACT_RESET);
        applyStimulus(0,  0,  0,  1,  C_RADD, 32'h8000, 32'h8001, 32'h0,    32'h214,  5,  2,  19, 0, ACT_LOAD);
        applyStimulus(0,  0,  0,  0,  12'h000,32'h0,    32'h0,    32'h0,    32'h0,    0,  0,  0,  0, ACT_LOAD);

`ifdef ID_EX_BUBBLE_CNT_EN
        // Drive the counter to 16'hFFFF, then one more flush wraps it to 0
        $display("[TB] running counter wrap sequence");
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(0, 0, 1, 0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, ACT_BUBBLE);
        end
        applyStimulus(0, 0, 1, 0, 12'h000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, ACT_BUBBLE);
`endif

        // Let the monitor drain the queue, bounded
        waitCycles = 0;
        while (scoreQ.size() != 0 && waitCycles < 10) begin
            @(posedge clk);
            #2;
            waitCycles++;
        end
        if (scoreQ.size() != 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard_drain: actual %0d pending, required 0", scoreQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of register-data, immediate and PC fields.
REQ-002 Parameter REG_AW, default 5: width of register-number fields.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port id_valid  input  1  decode stage holds a real instruction.
REQ-006 Port id_ctrl  input  12  control word: {lui, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchNE, BranchEQ, ALUOp[2:0]}.
REQ-007 Ports id_rd1, id_rd2, id_imm, id_pc4  input  DATA_W  read data 1/2, sign-extended immediate, PC+4.
REQ-008 Ports id_rs, id_rt, id_rd  input  REG_AW  source/destination register numbers.
REQ-009 Port stall_i  input  1  downstream stall; hold EX contents.
REQ-010 Port flush_i  input  1  branch-taken flush; kill instruction entering EX.
REQ-011 Ports ex_valid, ex_ctrl, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd  output  widths as inputs  registered EX-stage copies.
REQ-012 Port stall_o  output  1  combinational: freeze PC and IF/ID this cycle.
REQ-013 Port bubble_cnt  output  16  count of bubbles inserted (see Configuration).

Function
REQ-014 Load-use hazard SHALL be: ex_valid & ex_ctrl.MemRead & id_valid & (ex_rt != 0) & (ex_rt == id_rs | (ex_rt == id_rt & !id_ctrl.ALUSrc)).
REQ-015 stall_o SHALL equal stall_i | hazard, with no register delay.
REQ-016 Per-edge priority SHALL be: reset > stall_i (hold all) > flush_i (bubble) > hazard (bubble) > load.
REQ-017 Hold: every ex_* output SHALL keep its previous value.
REQ-018 Bubble: ex_valid=0 and ex_ctrl=0; data/register fields SHALL hold their previous values.
REQ-019 Load: all ex_* SHALL take id_* values; ex_ctrl SHALL be forced to 0 when id_valid=0.
REQ-020 Latency SHALL be exactly one cycle from id_* to ex_* on a load edge.
REQ-021 ex_valid=0 SHALL always imply ex_ctrl=0 (no stray RegWrite/MemWrite).
REQ-022 flush_i with hazard in the same cycle SHALL produce one bubble; stall_o still asserted.
REQ-023 stall_i with flush_i in the same cycle: hold wins; flush_i SHALL be re-presented by its source.
REQ-024 Two-state FSM {RUN, BUBBLE}: RUN->BUBBLE on hazard & !stall_i; BUBBLE->RUN next non-stalled edge; a hazard SHALL never insert two consecutive bubbles for the same instruction.

Reset
REQ-025 On reset edge: ex_valid=0, ex_ctrl=0, all data/register fields 0, FSM=RUN, bubble_cnt=0.
REQ-026 Reset mid-hazard or mid-stall SHALL discard pending state; stall_o SHALL be 0 in the first cycle after reset when id_valid=0.

Configuration
REQ-027 Macro ID_EX_BUBBLE_CNT_EN defined: bubble_cnt increments by 1 on every bubble edge (flush or hazard), wraps 16'hFFFF->0, holds under stall_i.
REQ-028 Macro ID_EX_BUBBLE_CNT_EN undefined: no counter flops; bubble_cnt tied to 0.

Structure
REQ-029 Shared package SHALL hold control-word bit-index constants, the 12-bit control-word type, ALUOp width and the all-zero NOP control constant.
REQ-030 One sub-module pipe_field_reg (parameterised width, enable, sync clear) SHALL be instantiated per field group.

Verification
REQ-031 Reset asserted with all inputs active -> next cycle all ex_* = 0, stall_o=0, bubble_cnt=0.
REQ-032 ADDI (id_ctrl=12'b00_101_00_00_100, id_rd1=5, id_imm=3) loaded -> one cycle later ex_ctrl=12'b001010000100, ex_valid=1.
REQ-033 lw (MemRead=1, ex_rt=8) in EX, id_rs=8 -> stall_o=1, next ex_valid=0, ex_ctrl=0, bubble_cnt=1; following cycle instruction loads.
REQ-034 lw with ex_rt=0, id_rs=0 -> stall_o=0, no bubble.
REQ-035 stall_i=1 and flush_i=1 together for 3 cycles -> ex_* unchanged throughout, bubble_cnt unchanged.
REQ-036 bubble_cnt preset to 16'hFFFF via 65535 flushes, one more flush -> bubble_cnt=0.
